// File: rtl/servile_uart_tx.sv
// servile_uart_tx: Wishbone UART transmitter, 2**FIFO_AW byte TX FIFO, bit period DIV+1 clocks; even parity when SERVILE_UART_TX_PARITY_EN.
// Latency: ack/rdt one cycle after stb is sampled; start bit begins the cycle after the ack cycle on an idle line.
// Backpressure: none on the bus; a DATA write to a full FIFO is acked, dropped and sets the sticky overflow flag.
module servile_uart_tx #(
  parameter int unsigned FIFO_AW   = 2,
  parameter logic [15:0] DIV_RESET = 16'd433
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic [3:0]  i_wb_sel,
  input  logic        i_wb_we,
  input  logic        i_wb_stb,
  output logic [31:0] o_wb_rdt,
  output logic        o_wb_ack,
  output logic        o_tx
);
  localparam int unsigned DEPTH = 1 << FIFO_AW;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef SERVILE_UART_TX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } state_t;

  state_t             state, state_nxt;
  logic [1:0]         reg_sel;
  logic               access, wr, rd;
  logic [FIFO_AW:0]   wptr, rptr;
  logic [7:0]         mem [DEPTH];
  logic               full, empty, push_req, push, pop;
  logic               ovf, busy;
  logic [15:0]        div, cnt;
  logic [2:0]         bit_idx;
  logic [7:0]         shreg;
  logic               bit_end;
  logic [31:0]        rdt_mux;
`ifdef SERVILE_UART_TX_PARITY_EN
  logic               par;
`endif
  logic               unused_bits;

  assign unused_bits = ^{i_wb_adr[31:4], i_wb_adr[1:0], i_wb_dat[31:16], i_wb_sel[3:2]};

  // Only the edge that raises ack counts as an access, so a held stb is never double-acked.
  assign reg_sel  = i_wb_adr[3:2];
  assign access   = i_wb_stb & ~o_wb_ack;
  assign wr       = access & i_wb_we;
  assign rd       = access & ~i_wb_we;
  assign full     = (wptr[FIFO_AW] != rptr[FIFO_AW]) && (wptr[FIFO_AW-1:0] == rptr[FIFO_AW-1:0]);
  assign empty    = (wptr == rptr);
  assign push_req = wr && (reg_sel == 2'd0) && i_wb_sel[0];
  assign push     = push_req & ~full;
  assign pop      = (state == ST_IDLE) && !empty;
  assign bit_end  = (cnt == 16'd0);

  always_comb begin
    rdt_mux = '0;
    case (reg_sel)
      2'd1:    rdt_mux = {28'd0, ovf, busy, empty, full};
      2'd2:    rdt_mux = {16'd0, div};
      default: rdt_mux = '0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_wb_ack <= 1'b0;
      o_wb_rdt <= '0;
      ovf      <= 1'b0;
      div      <= DIV_RESET;
    end else begin
      o_wb_ack <= access;
      o_wb_rdt <= rd ? rdt_mux : 32'd0;
      // Set wins over a same-edge STATUS read clear.
      ovf      <= (push_req & full) | (ovf & ~(rd && (reg_sel == 2'd1)));
      if (wr && (reg_sel == 2'd2)) begin
        if (i_wb_sel[0]) div[7:0]  <= i_wb_dat[7:0];
        if (i_wb_sel[1]) div[15:8] <= i_wb_dat[15:8];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) mem[wptr[FIFO_AW-1:0]] <= i_wb_dat[7:0];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (!empty) state_nxt = ST_START;
      ST_START:  if (bit_end) state_nxt = ST_DATA;
`ifdef SERVILE_UART_TX_PARITY_EN
      ST_DATA:   if (bit_end && bit_idx == 3'd7) state_nxt = ST_PARITY;
      ST_PARITY: if (bit_end) state_nxt = ST_STOP;
`else
      ST_DATA:   if (bit_end && bit_idx == 3'd7) state_nxt = ST_STOP;
`endif
      ST_STOP:   if (bit_end) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Counter reloads from the live divisor at every bit boundary, so DIV writes land at the next bit.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
`ifdef SERVILE_UART_TX_PARITY_EN
      par     <= 1'b0;
`endif
    end else if (state == ST_IDLE) begin
      cnt     <= div;
      bit_idx <= '0;
      if (pop) begin
        shreg <= mem[rptr[FIFO_AW-1:0]];
`ifdef SERVILE_UART_TX_PARITY_EN
        par   <= ^mem[rptr[FIFO_AW-1:0]];
`endif
      end
    end else if (bit_end) begin
      cnt <= div;
      if (state == ST_DATA) begin
        shreg   <= shreg >> 1;
        bit_idx <= bit_idx + 1'b1;
      end
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

  always_comb begin
    o_tx = 1'b1;
    busy = 1'b1;
    case (state)
      ST_IDLE:   busy = 1'b0;
      ST_START:  o_tx = 1'b0;
      ST_DATA:   o_tx = shreg[0];
`ifdef SERVILE_UART_TX_PARITY_EN
      ST_PARITY: o_tx = par;
`endif
      default:   o_tx = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_servile_uart_tx.sv
// Directed bench for servile_uart_tx: register access, frame shape, FIFO overflow, held strobe, reset abort.
module tb_servile_uart_tx;
`ifdef SERVILE_UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic        clk = 1'b0;
  logic        i_rst;
  logic [31:0] i_wb_adr, i_wb_dat;
  logic [3:0]  i_wb_sel;
  logic        i_wb_we, i_wb_stb;
  logic [31:0] o_wb_rdt;
  logic        o_wb_ack, o_tx;

  int          n_assert = 0;
  int          n_fail   = 0;
  int          bit_clks = 4;
  logic [7:0]  rx_q[$];

  servile_uart_tx dut (
    .i_clk(clk), .i_rst(i_rst), .i_wb_adr(i_wb_adr), .i_wb_dat(i_wb_dat),
    .i_wb_sel(i_wb_sel), .i_wb_we(i_wb_we), .i_wb_stb(i_wb_stb),
    .o_wb_rdt(o_wb_rdt), .o_wb_ack(o_wb_ack), .o_tx(o_tx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wb_xfer(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                         input logic we, output logic [31:0] rdt);
    @(negedge clk);
    i_wb_adr = adr; i_wb_dat = dat; i_wb_sel = sel; i_wb_we = we; i_wb_stb = 1'b1;
    @(posedge clk); #1;
    chk("ack_rise", {31'd0, o_wb_ack}, 32'd1);
    rdt = o_wb_rdt;
    i_wb_stb = 1'b0; i_wb_we = 1'b0;
    @(posedge clk); #1;
    chk("ack_single", {31'd0, o_wb_ack}, 32'd0);
  endtask

  // Background receiver: samples mid-bit at the bench's notion of the bit period.
  initial begin : rx_mon
    logic       prev;
    logic [7:0] b;
    prev = 1'b1;
    b    = '0;
    forever begin
      @(negedge clk);
      if (prev && !o_tx) begin
        repeat (bit_clks / 2) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
          repeat (bit_clks) @(negedge clk);
          b[k] = o_tx;
        end
        repeat (bit_clks * (NBITS - 9)) @(negedge clk);
        rx_q.push_back(b);
      end
      prev = o_tx;
    end
  end

  initial begin : stim
    logic [31:0] rdt;
    logic [7:0]  tx_byte;
    logic        exp_b;
    int          lows;
    int          waited;

    i_rst = 1'b1; i_wb_adr = '0; i_wb_dat = '0; i_wb_sel = '0; i_wb_we = 1'b0; i_wb_stb = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", {31'd0, o_wb_ack}, 32'd0);
    chk("rst_rdt", o_wb_rdt, 32'd0);
    chk("rst_tx",  {31'd0, o_tx}, 32'd1);
    i_rst = 1'b0;

    wb_xfer(32'h4, 32'd0, 4'hF, 1'b0, rdt);
    chk("status_after_rst", rdt, 32'h2);
    chk("tx_idle_high", {31'd0, o_tx}, 32'd1);

    // 0x55 at DIV=3: start, 1,0,1,0,1,0,1,0, [parity 0], stop, each 4 clocks.
    wb_xfer(32'h8, 32'd3, 4'h3, 1'b1, rdt);
    tx_byte = 8'h55;
    wb_xfer(32'h0, {24'd0, tx_byte}, 4'h1, 1'b1, rdt);
    for (int k = 0; k < NBITS; k++) begin
      if (k == 0)              exp_b = 1'b0;
      else if (k <= 8)         exp_b = tx_byte[k-1];
      else if (k == NBITS - 1) exp_b = 1'b1;
      else                     exp_b = ^tx_byte;
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        chk("frame55_bit", {31'd0, o_tx}, {31'd0, exp_b});
      end
    end
    @(negedge clk);
    chk("frame55_gap_idle", {31'd0, o_tx}, 32'd1);

    // Busy while a frame is on the wire, FIFO already drained by the pop.
    wb_xfer(32'h0, 32'hA3, 4'h1, 1'b1, rdt);
    wb_xfer(32'h4, 32'd0, 4'hF, 1'b0, rdt);
    chk("status_busy", rdt, 32'h6);
    repeat (60) @(posedge clk);
    #1;
    wb_xfer(32'h4, 32'd0, 4'hF, 1'b0, rdt);
    chk("status_done", rdt, 32'h2);

    // Strobe held four cycles on a DIV write: acks alternate, no third ack.
    @(negedge clk);
    i_wb_adr = 32'h8; i_wb_dat = 32'd7; i_wb_sel = 4'h3; i_wb_we = 1'b1; i_wb_stb = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      chk("held_stb_ack", {31'd0, o_wb_ack}, (k % 2 == 1) ? 32'd1 : 32'd0);
    end
    i_wb_stb = 1'b0; i_wb_we = 1'b0;
    @(posedge clk); #1;
    chk("held_stb_no_third", {31'd0, o_wb_ack}, 32'd0);
    wb_xfer(32'h8, 32'd0, 4'hF, 1'b0, rdt);
    chk("div_after_held", rdt, 32'd7);

    // Byte lane select on DIV, reserved slot, DATA reads zero.
    wb_xfer(32'h8, 32'h0000ABCD, 4'h2, 1'b1, rdt);
    wb_xfer(32'h8, 32'd0, 4'hF, 1'b0, rdt);
    chk("div_sel_hi_only", rdt, 32'h0000AB07);
    wb_xfer(32'hC, 32'hFFFFFFFF, 4'hF, 1'b1, rdt);
    wb_xfer(32'h8, 32'd0, 4'hF, 1'b0, rdt);
    chk("div_after_rsvd_wr", rdt, 32'h0000AB07);
    wb_xfer(32'hC, 32'd0, 4'hF, 1'b0, rdt);
    chk("rsvd_read", rdt, 32'd0);
    wb_xfer(32'h0, 32'd0, 4'hF, 1'b0, rdt);
    chk("data_read", rdt, 32'd0);

    // FIFO fill at DIV=100: 0x01 pops at once, 0x02..0x05 fill, 0x06 overflows.
    wb_xfer(32'h8, 32'd100, 4'h3, 1'b1, rdt);
    bit_clks = 101;
    rx_q.delete();
    for (int v = 1; v <= 6; v++) wb_xfer(32'h0, v, 4'h1, 1'b1, rdt);
    wb_xfer(32'h4, 32'd0, 4'hF, 1'b0, rdt);
    chk("status_full_ovf", rdt, 32'hD);
    wb_xfer(32'h4, 32'd0, 4'hF, 1'b0, rdt);
    chk("status_ovf_cleared", rdt, 32'h5);
    waited = 0;
    while (rx_q.size() < 5 && waited < 8000) begin
      @(posedge clk);
      waited++;
    end
    chk("five_frames_in_time", {31'd0, (rx_q.size() >= 5) ? 1'b1 : 1'b0}, 32'd1);
    repeat (1500) @(posedge clk);
    #1;
    chk("exactly_five_frames", 32'(rx_q.size()), 32'd5);
    for (int v = 0; v < 5; v++)
      chk("frame_byte", (v < rx_q.size()) ? {24'd0, rx_q[v]} : 32'hDEAD, 32'(v + 1));
    wb_xfer(32'h4, 32'd0, 4'hF, 1'b0, rdt);
    chk("status_after_fifo", rdt, 32'h2);

    // Reset mid DATA bit0 of 0xF0 with 0x77 still queued.
    wb_xfer(32'h8, 32'd3, 4'h3, 1'b1, rdt);
    bit_clks = 4;
    wb_xfer(32'h0, 32'hF0, 4'h1, 1'b1, rdt);
    wb_xfer(32'h0, 32'h77, 4'h1, 1'b1, rdt);
    repeat (3) @(posedge clk);
    #1;
    chk("mid_data_bit0", {31'd0, o_tx}, 32'd0);
    i_rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_tx_high_next", {31'd0, o_tx}, 32'd1);
    chk("rst_ack_low", {31'd0, o_wb_ack}, 32'd0);
    i_rst = 1'b0;
    wb_xfer(32'h4, 32'd0, 4'hF, 1'b0, rdt);
    chk("status_after_abort", rdt, 32'h2);
    wb_xfer(32'h8, 32'd0, 4'hF, 1'b0, rdt);
    chk("div_reset_value", rdt, 32'd433);
    lows = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (!o_tx) lows++;
    end
    chk("no_tx_after_rst", 32'(lows), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
